// File: rtl/mvau_stream_ctrl_pkg.sv
// rtl/mvau_stream_ctrl_pkg.sv - shared mvau_defn package: controller state enum and fold-size helpers
package mvau_defn;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } mvau_ctrl_state_t;

    function automatic int calc_sf(input int matrix_w, input int simd);
        return matrix_w / simd;
    endfunction

    function automatic int calc_nf(input int matrix_h, input int pe);
        return matrix_h / pe;
    endfunction

    // Address widths never collapse to zero bits, even for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_act_buf.sv
// rtl/mvau_act_buf.sv - simple dual-port activation buffer, synchronous write and registered read
module mvau_act_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register doubles as the controller's output register in READ.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mvau_stream_ctrl.sv
// rtl/mvau_stream_ctrl.sv - activation reuse sequencer for mvau_stream; optional MVAU_STREAM_CTRL_PERF_EN adds stall_cnt
module mvau_stream_ctrl
    import mvau_defn::*;
#(
    parameter int MatrixW = 16,
    parameter int MatrixH = 8,
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int TSrcI   = 4,
    localparam int SF         = calc_sf(MatrixW, SIMD),
    localparam int NF         = calc_nf(MatrixH, PE),
    localparam int WMEM_DEPTH = SF * NF,
    localparam int AW         = clog2_min1(WMEM_DEPTH),
    localparam int DW         = SIMD * TSrcI
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    output logic          in_rdy,
    input  logic [DW-1:0] in_act,
    input  logic          dp_rdy,
    output logic          wmem_en,
    output logic [AW-1:0] wmem_addr,
    output logic          out_v,
    output logic [DW-1:0] out_act,
    output logic          out_sf_last,
    output logic          out_nf_last
`ifdef MVAU_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int SFW = clog2_min1(SF);
    localparam int NFW = clog2_min1(NF);

    mvau_ctrl_state_t state_q, state_d;
    logic [SFW-1:0]   sf_q, sf_d;
    logic [NFW-1:0]   nf_q, nf_d;
    logic             fire;
    logic             sf_wrap;
    logic             nf_wrap;
    logic             out_v_q;
    logic             sf_last_q;
    logic             nf_last_q;
    logic             sel_buf_q;
    logic [DW-1:0]    pass_q;
    logic [DW-1:0]    buf_rd_data;

    assign sf_wrap = (sf_q == SFW'(SF - 1));
    assign nf_wrap = (nf_q == NFW'(NF - 1));

    always_comb begin
        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        fire    = ~rst & dp_rdy & ((state_q == READ) | in_v);
        in_rdy  = ~rst & dp_rdy & (state_q == WRITE);
        if (fire) begin
            sf_d = sf_wrap ? '0 : sf_q + 1'b1;
            if (sf_wrap) begin
                nf_d = nf_wrap ? '0 : nf_q + 1'b1;
            end
            case (state_q)
                WRITE: if (sf_wrap && (NF > 1)) state_d = READ;
                READ:  if (sf_wrap && nf_wrap)  state_d = WRITE;
                default: state_d = WRITE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WRITE;
            sf_q      <= '0;
            nf_q      <= '0;
            out_v_q   <= 1'b0;
            sf_last_q <= 1'b0;
            nf_last_q <= 1'b0;
            sel_buf_q <= 1'b0;
            pass_q    <= '0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            nf_q    <= nf_d;
            out_v_q <= fire;
            if (fire) begin
                sf_last_q <= sf_wrap;
                nf_last_q <= sf_wrap & nf_wrap;
                sel_buf_q <= (state_q == READ);
                if (state_q == WRITE) begin
                    pass_q <= in_act;
                end
            end
        end
    end

    mvau_act_buf #(
        .DEPTH (SF),
        .WIDTH (DW),
        .AW    (SFW)
    ) u_act_buf (
        .clk       (clk),
        .wr_en_i   (fire & (state_q == WRITE)),
        .wr_addr_i (sf_q),
        .wr_data_i (in_act),
        .rd_en_i   (fire & (state_q == READ)),
        .rd_addr_i (sf_q),
        .rd_data_o (buf_rd_data)
    );

    // Fold 0 uses the pass-through register; later folds read the buffer.
    assign out_act     = sel_buf_q ? buf_rd_data : pass_q;
    assign out_v       = out_v_q;
    assign out_sf_last = sf_last_q;
    assign out_nf_last = nf_last_q;
    assign wmem_en     = fire;
    assign wmem_addr   = AW'(int'(nf_q) * SF + int'(sf_q));

`ifdef MVAU_STREAM_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (~dp_rdy & ((state_q == READ) | in_v) & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mvau_stream_ctrl.sv
// tb/tb_mvau_stream_ctrl.sv - self-checking bench for mvau_stream_ctrl (NF=2 and NF=1 instances)
module tb_mvau_stream_ctrl;

    localparam int SF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_v = 1'b0;
    logic       dp_rdy = 1'b0;
    logic [7:0] in_act = 8'h00;

    logic       a_in_rdy, a_wmem_en, a_out_v, a_sfl, a_nfl;
    logic [2:0] a_wmem_addr;
    logic [7:0] a_out_act;
    logic       b_in_rdy, b_wmem_en, b_out_v, b_sfl, b_nfl;
    logic [1:0] b_wmem_addr;
    logic [7:0] b_out_act;
`ifdef MVAU_STREAM_CTRL_PERF_EN
    logic [31:0] a_stall_cnt, b_stall_cnt;
`endif

    mvau_stream_ctrl #(.MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .TSrcI(4)) dut_a (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(a_in_rdy), .in_act(in_act),
        .dp_rdy(dp_rdy), .wmem_en(a_wmem_en), .wmem_addr(a_wmem_addr),
        .out_v(a_out_v), .out_act(a_out_act), .out_sf_last(a_sfl), .out_nf_last(a_nfl)
`ifdef MVAU_STREAM_CTRL_PERF_EN
        , .stall_cnt(a_stall_cnt)
`endif
    );

    mvau_stream_ctrl #(.MatrixW(8), .MatrixH(2), .SIMD(2), .PE(2), .TSrcI(4)) dut_b (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(b_in_rdy), .in_act(in_act),
        .dp_rdy(dp_rdy), .wmem_en(b_wmem_en), .wmem_addr(b_wmem_addr),
        .out_v(b_out_v), .out_act(b_out_act), .out_sf_last(b_sfl), .out_nf_last(b_nfl)
`ifdef MVAU_STREAM_CTRL_PERF_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a vector is SF*m_nf beats indexed by m_k; the first SF accept input.
    int         m_k, m_nf, sel, m_stall, m_stall_seen;
    logic [7:0] m_vec [SF];
    logic       r_ov, r_sfl, r_nfl;
    logic [7:0] r_act;
    logic [15:0] exp_vec, obs_vec;

    task automatic model_reset(input int nf);
        m_k = 0; m_nf = nf; m_stall = 0; m_stall_seen = 0;
        r_ov = 1'b0; r_act = 8'h00; r_sfl = 1'b0; r_nfl = 1'b0;
    endtask

    task automatic tick(input logic v, input logic dp, input logic [7:0] a);
        logic e_in, e_fire, ov, sfl, nfl, en, rdy;
        logic [7:0] act;
        logic [2:0] addr;
        @(posedge clk);
        #1;
        in_v = v; dp_rdy = dp; in_act = a;
        #3;
        e_in   = dp && (m_k < SF);
        e_fire = dp && ((m_k < SF) ? v : 1'b1);
        exp_vec = {r_ov, r_ov ? r_act : 8'h00, r_ov & r_sfl, r_ov & r_nfl, e_fire, 3'(m_k), e_in};
        if (sel == 0) begin
            ov = a_out_v; act = a_out_act; sfl = a_sfl; nfl = a_nfl;
            en = a_wmem_en; addr = a_wmem_addr; rdy = a_in_rdy;
        end else begin
            ov = b_out_v; act = b_out_act; sfl = b_sfl; nfl = b_nfl;
            en = b_wmem_en; addr = {1'b0, b_wmem_addr}; rdy = b_in_rdy;
        end
        obs_vec = {ov, r_ov ? act : 8'h00, r_ov & sfl, r_ov & nfl, en, addr, rdy};
        m_stall_seen = m_stall;
        if (!dp && ((m_k >= SF) || v)) m_stall++;
        if (e_fire) begin
            if (m_k < SF) m_vec[m_k] = a;
            r_ov  = 1'b1;
            r_act = m_vec[m_k % SF];
            r_sfl = ((m_k % SF) == SF - 1);
            r_nfl = (m_k == SF * m_nf - 1);
            m_k   = (m_k + 1) % (SF * m_nf);
        end else begin
            r_ov = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int nf);
        @(posedge clk);
        #2;
        rst = 1'b1; in_v = 1'b0; dp_rdy = 1'b1;
        model_reset(nf);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        in_v = 1'b1; dp_rdy = 1'b1; in_act = 8'hFF;
        #1;
        n_tests++;
        if ({a_out_v, a_out_act, a_sfl, a_nfl, a_wmem_en, a_wmem_addr, a_in_rdy} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {a_out_v, a_out_act, a_sfl, a_nfl, a_wmem_en, a_wmem_addr, a_in_rdy});
        end
        n_tests++;
        if ({b_out_v, b_out_act, b_sfl, b_nfl, b_wmem_en, b_wmem_addr, b_in_rdy} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {b_out_v, b_out_act, b_sfl, b_nfl, b_wmem_en, b_wmem_addr, b_in_rdy});
        end
`ifdef MVAU_STREAM_CTRL_PERF_EN
        n_tests++;
        if (a_stall_cnt !== 32'd0 || b_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d/%0d want 0", a_stall_cnt, b_stall_cnt);
        end
`endif
        in_v = 1'b0;
        model_reset(2);
        sel = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] beats [4];
        logic [7:0] want_act [8];
        logic [7:0] got_act [$];
        logic       got_sfl [$];
        logic       got_nfl [$];
        logic       got_rdy [$];
        beats    = '{8'h11, 8'h22, 8'h33, 8'h44};
        want_act = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int c = 0; c < 9; c++) begin
            tick(c < 4, 1'b1, (c < 4) ? beats[c] : 8'h00);
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stream cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (c < 8) got_rdy.push_back(a_in_rdy);
            if (a_out_v) begin
                got_act.push_back(a_out_act); got_sfl.push_back(a_sfl); got_nfl.push_back(a_nfl);
            end
        end
        n_tests++;
        if (got_act.size() != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d beats want 8", got_act.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (got_act[i] !== want_act[i] || got_sfl[i] !== (i == 3 || i == 7) || got_nfl[i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got %h/%b/%b want %h/%b/%b", i, got_act[i], got_sfl[i],
                             got_nfl[i], want_act[i], (i == 3 || i == 7), (i == 7));
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_rdy[i] !== (i < 4)) begin
                n_fail++;
                $display("FAIL stream_in_rdy cyc%0d: got %b want %b", i + 1, got_rdy[i], (i < 4));
            end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 30; c++) begin
            tick(1'b1, (c % 3) != 2, 8'($urandom));
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stall cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        for (int c = 0; c < 16 && m_k != 0; c++) tick(1'b1, 1'b1, 8'($urandom));
        tick(1'b0, 1'b1, 8'h00);
`ifdef MVAU_STREAM_CTRL_PERF_EN
        n_tests++;
        if (a_stall_cnt !== 32'(m_stall_seen)) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want %0d", a_stall_cnt, m_stall_seen);
        end
`endif
    endtask

    task automatic test_read_in_v();
        logic [7:0] seen_act;
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, 1'b1, (c == 8) ? 8'h55 : 8'($urandom_range(8'h60, 8'hFF)));
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL read_in_v cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (c == 8) begin
                n_tests++;
                if (a_wmem_addr !== 3'd0 || a_in_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_in_v_restart: got addr %0d rdy %b want 0/1", a_wmem_addr, a_in_rdy);
                end
            end
        end
        seen_act = a_out_act;
        n_tests++;
        if (seen_act !== 8'h55) begin
            n_fail++;
            $display("FAIL read_in_v_first: got %h want 55", seen_act);
        end
        for (int c = 0; c < 16 && m_k != 0; c++) tick(1'b1, 1'b1, 8'($urandom));
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        for (int c = 0; c < 16 && m_k != 0; c++) tick(1'b1, 1'b1, 8'($urandom));
    endtask

    task automatic test_reset_mid();
        int outs = 0;
        for (int c = 0; c < 20 && outs < 6; c++) begin
            tick(1'b1, 1'b1, 8'($urandom));
            if (exp_vec[15]) outs++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({a_out_v, a_out_act, a_sfl, a_nfl, a_wmem_en, a_wmem_addr, a_in_rdy} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 0", {a_out_v, a_out_act, a_sfl, a_nfl, a_wmem_en, a_wmem_addr, a_in_rdy});
        end
        in_v = 1'b0; dp_rdy = 1'b1;
        model_reset(2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick(c < 4, 1'b1, 8'hA1 + 8'(c));
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_nf1();
        sel = 1;
        pulse_reset(1);
        for (int c = 0; c < 60; c++) begin
            if (c < 9) tick(c < 8, 1'b1, 8'($urandom));
            else       tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'($urandom));
            n_tests++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL nf1 cyc%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        sel = 0;
        model_reset(2);
        test_reset();
        test_stream();
        test_stall();
        test_read_in_v();
        test_random();
        test_reset_mid();
        test_nf1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvau_stream_ctrl.md
# mvau_stream_ctrl

Sequencer in front of the `mvau_stream` datapath. It accepts each input activation vector once over a valid/ready stream and buffers it. It replays the vector for every neuron fold, generating weight-memory addresses in lockstep so that weights and activations reach the datapath aligned. It replaces the hand-timed activation reuse and weight streaming currently done by the bench, and is the first step toward a self-contained MVAU layer.

## Interface
- `MatrixW`, 16: weight matrix width (dot-product length).
- `MatrixH`, 8: weight matrix height (output channels).
- `SIMD`, 2: activations per beat. `MatrixW % SIMD == 0`.
- `PE`, 2: output channels per fold. `MatrixH % PE == 0`.
- `TSrcI`, 4: activation element width.
- Derived localparams: `SF = MatrixW/SIMD`, `NF = MatrixH/PE`, `WMEM_DEPTH = SF*NF`, `AW = $clog2(WMEM_DEPTH)` (minimum 1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_v` in 1: input activation beat valid.
- `in_rdy` out 1: controller accepts beat.
- `in_act` in SIMD*TSrcI: input activation beat.
- `dp_rdy` in 1: datapath can take a beat this cycle.
- `wmem_en` out 1: weight memory read enable (1-cycle read latency).
- `wmem_addr` out AW: weight memory address, `nf*SF + sf`.
- `out_v` out 1: activation beat to datapath valid.
- `out_act` out SIMD*TSrcI: activation beat to datapath.
- `out_sf_last` out 1: beat is last of a dot product (accumulator flush).
- `out_nf_last` out 1: beat is last of the whole vector.

## Operation
- The state machine has two states, WRITE (reset state) and READ. It keeps two counters: `sf` in 0..SF-1 and `nf` in 0..NF-1. Both reset to 0.
- `fire = wmem_en`:
  - In WRITE: `fire = in_v & dp_rdy`.
  - In READ: `fire = dp_rdy`.
- `in_rdy = (state==WRITE) & dp_rdy`. This is combinational and does not depend on `in_v`.
- WRITE, on fire:
  - Write `in_act` to buffer entry `sf`.
  - Register `in_act` to `out_act` (pass-through; the beat is used by fold 0 immediately).
- READ, on fire: register buffer entry `sf` to `out_act`.
- Counter advance on fire:
  - `sf` increments and wraps at SF-1.
  - On wrap, `nf` increments and wraps at NF-1.
- Transitions:
  - WRITE→READ when fire and `sf==SF-1` and `NF>1`. At that point `nf` becomes 1.
  - READ→WRITE when fire and `sf==SF-1` and `nf==NF-1`.
  - With `NF==1`, the block never leaves WRITE.
- No fire means counters, state and buffer hold. `in_act` is ignored when `in_rdy` is low.
- `out_sf_last` and `out_nf_last` are registered with `out_act`, from `sf==SF-1` and `(sf==SF-1)&(nf==NF-1)`.
- Buffer has SF entries × SIMD*TSrcI bits. The write port (WRITE) and read port (READ) are never active in the same cycle, so there is no read-during-write hazard.

## Timing
- Reset values: `out_v=0`, `out_act=0`, `out_sf_last=0`, `out_nf_last=0`, `wmem_en=0`, `wmem_addr=0`, `in_rdy=0` while `rst` is asserted. Buffer contents are not reset.
- Latency is 1 cycle. `out_v`, `out_act` and the flags appear the cycle after fire. Weight data for the same beat arrives from memory in that same cycle.
- `out_v` is 0 in any cycle following a non-fire cycle.
- Throughput: 1 beat/cycle with `dp_rdy` high. A vector costs SF*NF cycles, of which only SF accept input.
- `dp_rdy` low stalls both states with no state change. `wmem_en` goes low the same cycle.
- If `rst` is asserted mid-vector, the partial vector is discarded and the block restarts in WRITE at `sf=nf=0`. The upstream must resend the whole vector.

## Configuration
- `MVAU_STREAM_CTRL_PERF_EN` defined adds output `stall_cnt` (32-bit). It counts cycles where `dp_rdy==0` and (state==READ or `in_v==1`).
  - Resets to 0.
  - Saturates at all-ones.
- Undefined: no port and no counter logic.

## Structure
- Place `SF`/`NF` helper functions and the `mvau_ctrl_state_t` enum {WRITE, READ} in the shared `mvau_defn` package.
- One sub-module: `mvau_act_buf`. It is a simple dual-port register array with SF entries, SIMD*TSrcI bits wide, with synchronous write and synchronous read. The controller owns the output register through the read port.

## Test plan
All scenarios use MatrixW=8, SIMD=2 (SF=4), MatrixH=4, PE=2 (NF=2) unless stated.
- Stream beats 0x11,0x22,0x33,0x44 with `dp_rdy=1` → `out_act` sequence 0x11,0x22,0x33,0x44,0x11,0x22,0x33,0x44. `wmem_addr` runs 0..7. `in_rdy` is low for cycles 5–8. `out_sf_last` is high on the 4th and 8th beats, and `out_nf_last` only on the 8th.
- Toggle `dp_rdy` low every 3rd cycle during READ → same sequence with no duplicated or missing beats, and `wmem_addr` held during stalls. With the macro defined, `stall_cnt` equals the number of low cycles.
- Assert `in_v` while in READ → no acceptance and `in_rdy=0`. Beat 0x55 is accepted as the first beat of the next vector, and `wmem_addr` returns to 0.
- Assert `rst` after the 6th output beat → all outputs 0 asynchronously. After release, the next vector 0xA1.. is output from `wmem_addr=0`.
- With MatrixH=2, PE=2 (NF=1), stream 8 beats back-to-back → pure pass-through. `in_rdy` stays high and `wmem_addr` cycles 0..3 twice.
- Random weights and activations with all four `TSrcI`/`TW` binary combinations, run end-to-end with `mvau_stream` → every output matches the behavioural MVAU model.
